// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side inputs, register-file write port, decode bypass and retire count of the writeback stage
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [RA_W-1:0]  in_rd;
  logic             in_ruWr;
  logic [1:0]       in_wbSrc;
  logic [XLEN-1:0]  in_aluRes;
  logic [XLEN-1:0]  in_dmData;
  logic [XLEN-1:0]  in_pcInc;
  logic [RA_W-1:0]  rs1;
  logic [RA_W-1:0]  rs2;
  logic [XLEN-1:0]  ruRs1_raw;
  logic [XLEN-1:0]  ruRs2_raw;
  logic [RA_W-1:0]  rd;
  logic [XLEN-1:0]  dataWr;
  logic             ruWr;
  logic [XLEN-1:0]  ruRs1_fwd;
  logic [XLEN-1:0]  ruRs2_fwd;
  logic             wb_valid;
  logic [CNT_W-1:0] instret;
  modport master (
    output stall, flush, in_valid, in_rd, in_ruWr, in_wbSrc, in_aluRes, in_dmData, in_pcInc,
           rs1, rs2, ruRs1_raw, ruRs2_raw,
    input  rd, dataWr, ruWr, ruRs1_fwd, ruRs2_fwd, wb_valid, instret
  );
  modport slave (
    input  stall, flush, in_valid, in_rd, in_ruWr, in_wbSrc, in_aluRes, in_dmData, in_pcInc,
           rs1, rs2, ruRs1_raw, ruRs2_raw,
    output rd, dataWr, ruWr, ruRs1_fwd, ruRs2_fwd, wb_valid, instret
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register driving the register-file write port, write-through decode bypass, retire counter
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input logic      clk,
  input logic      rst_n,
  wb_stage_if.slave bus
);
  logic             validQ;
  logic             ruWrQ;
  logic [RA_W-1:0]  rdQ;
  logic [1:0]       wbSrcQ;
  logic [XLEN-1:0]  aluResQ;
  logic [XLEN-1:0]  dmDataQ;
  logic [XLEN-1:0]  pcIncQ;
  logic [CNT_W-1:0] instretQ;
  logic [XLEN-1:0]  dataWr;
  logic             ruWr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      validQ   <= 1'b0;
      ruWrQ    <= 1'b0;
      rdQ      <= '0;
      wbSrcQ   <= '0;
      aluResQ  <= '0;
      dmDataQ  <= '0;
      pcIncQ   <= '0;
      instretQ <= '0;
    end else begin
      // the WB instruction retires whenever it leaves, including when a flush overrides a stall
      instretQ <= instretQ + CNT_W'(validQ & (~bus.stall | bus.flush));
      if (bus.flush)
        validQ <= 1'b0;
      else if (!bus.stall) begin
        validQ  <= bus.in_valid;
        ruWrQ   <= bus.in_ruWr;
        rdQ     <= bus.in_rd;
        wbSrcQ  <= bus.in_wbSrc;
        aluResQ <= bus.in_aluRes;
        dmDataQ <= bus.in_dmData;
        pcIncQ  <= bus.in_pcInc;
      end
    end
  always_comb begin
    dataWr = wbSrcQ == 2'b00 ? aluResQ : wbSrcQ == 2'b01 ? dmDataQ : wbSrcQ == 2'b10 ? pcIncQ : '0;
    ruWr   = validQ & ruWrQ & (rdQ != '0);
  end
  assign bus.rd        = rdQ;
  assign bus.dataWr    = dataWr;
  assign bus.ruWr      = ruWr;
  assign bus.wb_valid  = validQ;
  assign bus.instret   = instretQ;
  // registers_unit commits on the edge, so a same-cycle read of rd must see the data being written
  assign bus.ruRs1_fwd = bus.rs1 == '0 ? '0 : (ruWr && rdQ == bus.rs1) ? dataWr : bus.ruRs1_raw;
  assign bus.ruRs2_fwd = bus.rs2 == '0 ? '0 : (ruWr && rdQ == bus.rs2) ? dataWr : bus.ruRs2_raw;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; a 4-bit-counter twin exercises counter wraparound
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(64)) bus ();
  wb_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(4))  bus4 ();

  wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  assign bus4.stall     = bus.stall;
  assign bus4.flush     = bus.flush;
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_rd     = bus.in_rd;
  assign bus4.in_ruWr   = bus.in_ruWr;
  assign bus4.in_wbSrc  = bus.in_wbSrc;
  assign bus4.in_aluRes = bus.in_aluRes;
  assign bus4.in_dmData = bus.in_dmData;
  assign bus4.in_pcInc  = bus.in_pcInc;
  assign bus4.rs1       = bus.rs1;
  assign bus4.rs2       = bus.rs2;
  assign bus4.ruRs1_raw = bus.ruRs1_raw;
  assign bus4.ruRs2_raw = bus.ruRs2_raw;

  typedef struct {
    logic        valid;
    logic        wr;
    logic        known;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [63:0] cnt;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: the instruction sitting in WB, with its write data already selected
  logic        mValid, mWe, mKnown;
  logic [4:0]  mRd;
  logic [31:0] mData;
  logic [63:0] mCnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a, d, p);
    logic [31:0] opts [4];
    opts = '{a, d, p, 32'h0};
    return opts[s];
  endfunction

  function automatic logic [31:0] fwdOf(input logic [4:0] rs, input logic [31:0] raw);
    logic writes;
    writes = mValid && mWe && mRd != 5'd0;
    if (rs == 5'd0) return 32'h0;
    if (writes && rs == mRd) return mData;
    return raw;
  endfunction

  task automatic modelReset();
    mValid = 0; mWe = 0; mKnown = 1; mRd = 0; mData = 0; mCnt = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    bus.in_valid = v; bus.in_rd = r; bus.in_ruWr = w; bus.in_wbSrc = s;
    bus.in_aluRes = a; bus.in_dmData = d; bus.in_pcInc = p;
  endtask

  // called at a negedge with inputs set: records the expected outputs, then advances the model
  task automatic tick();
    exp_t e;
    #1;
    e.valid = mValid;
    e.wr    = mValid && mWe && mRd != 5'd0;
    e.known = mKnown;
    e.rd    = mRd;
    e.data  = mData;
    e.fwd1  = fwdOf(bus.rs1, bus.ruRs1_raw);
    e.fwd2  = fwdOf(bus.rs2, bus.ruRs2_raw);
    e.cnt   = mCnt;
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (mValid && (!bus.stall || bus.flush)) mCnt = mCnt + 64'd1;
      if (bus.flush) begin
        mValid = 0; mKnown = 0;
      end else if (!bus.stall) begin
        mValid = bus.in_valid; mRd = bus.in_rd; mWe = bus.in_ruWr; mKnown = 1;
        mData  = pick(bus.in_wbSrc, bus.in_aluRes, bus.in_dmData, bus.in_pcInc);
      end
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_valid", 64'(bus.wb_valid), 64'(e.valid));
        chk("ruWr", 64'(bus.ruWr), 64'(e.wr));
        chk("ruWr4", 64'(bus4.ruWr), 64'(e.wr));
        if (e.known) begin
          chk("rd", 64'(bus.rd), 64'(e.rd));
          chk("dataWr", 64'(bus.dataWr), 64'(e.data));
        end
        chk("ruRs1_fwd", 64'(bus.ruRs1_fwd), 64'(e.fwd1));
        chk("ruRs2_fwd", 64'(bus.ruRs2_fwd), 64'(e.fwd2));
        chk("instret", bus.instret, e.cnt);
        chk("instret4", 64'(bus4.instret), 64'(e.cnt[3:0]));
      end
    end
  end

  initial begin : stim
    bus.stall = 0; bus.flush = 0;
    bus.rs1 = 0; bus.rs2 = 0;
    bus.ruRs1_raw = $urandom; bus.ruRs2_raw = $urandom;
    drive(0, 0, 0, 0, 0, 0, 0);
    modelReset();
    @(negedge clk);
    bus.rs1 = 5'd4; bus.rs2 = 5'd9;
    tick();
    tick();
    rst_n = 1;
    // first load and same-cycle bypass of a stale register-file read
    drive(1, 1, 1, 2'b00, 32'h12345678, 32'h0, 32'h0);
    bus.rs1 = 1; bus.ruRs1_raw = 32'h0bad0bad;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    // write-data source sweep with rs2 tracking rd
    bus.rs2 = 2; bus.ruRs2_raw = 32'hcafef00d;
    for (int s = 0; s < 4; s++) begin
      drive(1, 2, 1, 2'(s), 32'hA, 32'h87654321, 32'h104);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    // x0 writes are suppressed and x0 reads are zero
    drive(1, 0, 1, 2'b00, 32'hFFFFFFFF, 0, 0);
    bus.rs1 = 0; bus.ruRs1_raw = 32'hDEADBEEF;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    // stall holds the write for several cycles
    bus.rs1 = 3;
    drive(1, 3, 1, 2'b00, 32'h55, 0, 0);
    tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'($urandom_range(1, 31)), 1, 2'($urandom), $urandom, $urandom, $urandom);
      tick();
    end
    bus.stall = 0;
    drive(1, 4, 1, 2'b00, 32'h66, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    // flush beats stall; the instruction in WB still retires once
    drive(1, 5, 1, 2'b00, 32'h77, 0, 0);
    tick();
    bus.flush = 1; bus.stall = 1;
    drive(1, 6, 1, 2'b00, 32'h88, 0, 0);
    tick();
    bus.flush = 0; bus.stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    // asynchronous reset between edges while an instruction is held
    drive(1, 7, 1, 2'b00, 32'h99, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 0;
    #1;
    chk("async_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("async_ruWr", 64'(bus.ruWr), 64'd0);
    chk("async_instret", bus.instret, 64'd0);
    chk("async_instret4", 64'(bus4.instret), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
    // random traffic; small register range keeps the bypass busy, 4-bit twin wraps many times
    for (int i = 0; i < 400; i++) begin
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            2'($urandom), $urandom, $urandom, $urandom);
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      bus.ruRs1_raw = $urandom;
      bus.ruRs2_raw = $urandom;
      tick();
    end
    bus.stall = 0; bus.flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
